// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit_if
// Purpose  : Groups the fetch unit's control, ROM and decode-side signals.
//            The 'master' modport is the fetch unit's view. It drives the ROM
//            address and presents the IR to decode. The 'slave' modport is the
//            environment's view: the ROM, decode and run control.
// Signals  : start, stall, branch_en, branch_rel, branch_target, halt
//              - run control and decode feedback (into the fetch unit)
//            instr_in                        - ROM data for pc (into the unit)
//            pc                              - ROM fetch address (from the unit)
//            instr_out, ir_pc, instr_valid   - IR presented to decode
//            done, cycle_count               - run status
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_unit_if #(
   parameter int P_WIDTH = 10,
   parameter int I_WIDTH = 9
);
   logic                start;
   logic                stall;
   logic                branch_en;
   logic                branch_rel;
   logic [P_WIDTH-1:0]  branch_target;
   logic                halt;
   logic [P_WIDTH-1:0]  pc;
   logic [I_WIDTH-1:0]  instr_in;
   logic [I_WIDTH-1:0]  instr_out;
   logic [P_WIDTH-1:0]  ir_pc;
   logic                instr_valid;
   logic                done;
   logic [15:0]         cycle_count;

   modport master (
      input  start, stall, branch_en, branch_rel, branch_target, halt, instr_in,
      output pc, instr_out, ir_pc, instr_valid, done, cycle_count
   );

   modport slave (
      output start, stall, branch_en, branch_rel, branch_target, halt, instr_in,
      input  pc, instr_out, ir_pc, instr_valid, done, cycle_count
   );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch stage with a single IR register. It walks the
//            PC through a combinational instruction ROM and supports stalls,
//            absolute and pc-relative branches, and halt. It also counts the
//            cycles spent in RUN.
// Ports    : clk    - clock, rising edge
//            rst_n  - asynchronous active-low reset
//            bus    - fetch_unit_if.master, which carries:
//                     start/stall/branch_*/halt  (in)
//                     instr_in                   (in, ROM data for pc)
//                     pc                         (out, ROM address)
//                     instr_out/ir_pc/instr_valid (out, IR to decode)
//                     done/cycle_count           (out, run status)
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
   parameter int                 P_WIDTH    = 10,
   parameter int                 I_WIDTH    = 9,
   parameter logic [P_WIDTH-1:0] START_ADDR = '0
) (
   input  wire logic     clk,
   input  wire logic     rst_n,
   fetch_unit_if.master  bus
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   localparam logic [15:0] c_cc_max = 16'hFFFF;

   state_t              r_state,   w_state_nxt;
   logic [P_WIDTH-1:0]  r_pc,      w_pc_nxt;
   logic [I_WIDTH-1:0]  r_ir,      w_ir_nxt;
   logic [P_WIDTH-1:0]  r_ir_pc,   w_ir_pc_nxt;
   logic                r_valid,   w_valid_nxt;
   logic                r_done,    w_done_nxt;
   logic [15:0]         r_cc,      w_cc_nxt;

   logic [P_WIDTH-1:0]  w_target;
   logic [15:0]         w_cc_inc;

   // A relative offset is taken from the branch instruction's own address,
   // which is ir_pc and not the already-advanced pc. The sum wraps naturally.
   assign w_target = bus.branch_rel ? (r_ir_pc + bus.branch_target) : bus.branch_target;
   assign w_cc_inc = (r_cc == c_cc_max) ? r_cc : (r_cc + 16'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_pc    <= START_ADDR;
         r_ir    <= '0;
         r_ir_pc <= '0;
         r_valid <= 1'b0;
         r_done  <= 1'b0;
         r_cc    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_ir    <= w_ir_nxt;
         r_ir_pc <= w_ir_pc_nxt;
         r_valid <= w_valid_nxt;
         r_done  <= w_done_nxt;
         r_cc    <= w_cc_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_ir_nxt    = r_ir;
      w_ir_pc_nxt = r_ir_pc;
      w_valid_nxt = r_valid;
      w_done_nxt  = r_done;
      w_cc_nxt    = r_cc;

      case (r_state)
         ST_IDLE: begin
            if (bus.start) begin
               w_pc_nxt    = START_ADDR;
               w_cc_nxt    = '0;
               w_state_nxt = ST_RUN;
            end
         end

         ST_RUN: begin
            w_cc_nxt = w_cc_inc;
            // Halt and branch only apply when they decode a live IR, so a
            // flushed slot cannot redirect or stop the machine. Stall is
            // honoured regardless of IR validity.
            if (r_valid && bus.halt) begin
               w_state_nxt = ST_HALTED;
               w_valid_nxt = 1'b0;
               w_done_nxt  = 1'b1;
            end else if (r_valid && bus.branch_en) begin
               // The instruction fetched in this slot is wrong-path. It is
               // dropped by clearing valid, and the target is fetched next.
               w_pc_nxt    = w_target;
               w_valid_nxt = 1'b0;
            end else if (!bus.stall) begin
               w_ir_nxt    = bus.instr_in;
               w_ir_pc_nxt = r_pc;
               w_valid_nxt = 1'b1;
               w_pc_nxt    = r_pc + 1'b1;
            end
         end

         ST_HALTED: begin
            if (bus.start) begin
               w_done_nxt  = 1'b0;
               w_cc_nxt    = '0;
               w_pc_nxt    = START_ADDR;
               w_state_nxt = ST_RUN;
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign bus.pc          = r_pc;
   assign bus.instr_out   = r_ir;
   assign bus.ir_pc       = r_ir_pc;
   assign bus.instr_valid = r_valid;
   assign bus.done        = r_done;
   assign bus.cycle_count = r_cc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit. A reference model predicts
//            the output state after each clock. The prediction is queued when
//            the inputs are driven and compared after the edge. Directed
//            checks cover reset, branch, wrap, stall, halt and restart cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

   localparam int          c_pw    = 10;
   localparam int          c_iw    = 9;
   localparam logic [9:0]  c_start = 10'h000;

   localparam int c_idle = 0;
   localparam int c_run  = 1;
   localparam int c_halt = 2;

   typedef struct packed {
      logic [9:0]  pc;
      logic [8:0]  ir;
      logic [9:0]  irpc;
      logic        valid;
      logic        done;
      logic [15:0] cc;
   } exp_t;

   logic clk;
   logic rst_n;

   fetch_unit_if #(.P_WIDTH(c_pw), .I_WIDTH(c_iw)) bus ();

   fetch_unit #(
      .P_WIDTH    (c_pw),
      .I_WIDTH    (c_iw),
      .START_ADDR (c_start)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // The ROM contents are address + 1, truncated to the instruction width.
   function automatic logic [8:0] rom_f(input logic [9:0] a);
      return a[8:0] + 9'd1;
   endfunction

   assign bus.instr_in = rom_f(bus.pc);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb_q[$];

   // Reference model state
   int          m_state;
   logic [9:0]  m_pc;
   logic [8:0]  m_ir;
   logic [9:0]  m_irpc;
   logic        m_valid;
   logic        m_done;
   logic [15:0] m_cc;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = c_idle;
      m_pc    = c_start;
      m_ir    = '0;
      m_irpc  = '0;
      m_valid = 1'b0;
      m_done  = 1'b0;
      m_cc    = '0;
   endtask

   // Drive one cycle of inputs, queue the predicted post-edge state, then
   // advance to just past the edge.
   task automatic tick(input logic st, input logic stl, input logic br,
                       input logic rel, input logic [9:0] tgt, input logic hlt);
      exp_t e;
      bus.start         = st;
      bus.stall         = stl;
      bus.branch_en     = br;
      bus.branch_rel    = rel;
      bus.branch_target = tgt;
      bus.halt          = hlt;
      case (m_state)
         c_idle: begin
            if (st) begin
               m_pc    = c_start;
               m_cc    = '0;
               m_state = c_run;
            end
         end
         c_run: begin
            if (m_cc != 16'hFFFF) m_cc = m_cc + 16'd1;
            if (m_valid && hlt) begin
               m_state = c_halt;
               m_valid = 1'b0;
               m_done  = 1'b1;
            end else if (m_valid && br) begin
               m_pc    = rel ? (m_irpc + tgt) : tgt;
               m_valid = 1'b0;
            end else if (!stl) begin
               m_ir    = rom_f(m_pc);
               m_irpc  = m_pc;
               m_valid = 1'b1;
               m_pc    = m_pc + 10'd1;
            end
         end
         default: begin
            if (st) begin
               m_done  = 1'b0;
               m_cc    = '0;
               m_pc    = c_start;
               m_state = c_run;
            end
         end
      endcase
      e.pc    = m_pc;
      e.ir    = m_ir;
      e.irpc  = m_irpc;
      e.valid = m_valid;
      e.done  = m_done;
      e.cc    = m_cc;
      sb_q.push_back(e);
      @(posedge clk);
      #2;
   endtask

   task automatic nrm();
      tick(1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0);
   endtask

   // Scoreboard monitor. It compares 1 time unit after each edge; the
   // driver changes inputs 2 time units after the edge.
   always begin
      exp_t e;
      @(posedge clk);
      #1;
      if (rst_n && sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check_eq("sb_pc",    32'(bus.pc),          32'(e.pc));
         check_eq("sb_ir",    32'(bus.instr_out),   32'(e.ir));
         check_eq("sb_irpc",  32'(bus.ir_pc),       32'(e.irpc));
         check_eq("sb_valid", 32'(bus.instr_valid), 32'(e.valid));
         check_eq("sb_done",  32'(bus.done),        32'(e.done));
         check_eq("sb_cc",    32'(bus.cycle_count), 32'(e.cc));
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check_reset_values(input string pfx);
      check_eq({pfx, "_pc"},    32'(bus.pc),          32'(c_start));
      check_eq({pfx, "_ir"},    32'(bus.instr_out),   32'h0);
      check_eq({pfx, "_irpc"},  32'(bus.ir_pc),       32'h0);
      check_eq({pfx, "_valid"}, 32'(bus.instr_valid), 32'h0);
      check_eq({pfx, "_done"},  32'(bus.done),        32'h0);
      check_eq({pfx, "_cc"},    32'(bus.cycle_count), 32'h0);
   endtask

   initial begin
      logic [9:0]  s_pc;
      logic [8:0]  s_ir;
      logic [15:0] s_cc;

      rst_n             = 1'b0;
      bus.start         = 1'b0;
      bus.stall         = 1'b0;
      bus.branch_en     = 1'b0;
      bus.branch_rel    = 1'b0;
      bus.branch_target = '0;
      bus.halt          = 1'b0;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #2;
      check_reset_values("rst");
      rst_n = 1'b1;

      // The unit stays idle without start.
      nrm();
      tick(1'b0, 1'b1, 1'b1, 1'b0, 10'h055, 1'b1);

      // Sequential run from the start address.
      tick(1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0);
      check_eq("start_valid", 32'(bus.instr_valid), 32'h0);
      nrm();
      check_eq("seq0_ir", 32'(bus.instr_out), 32'h001);
      nrm();
      check_eq("seq1_ir", 32'(bus.instr_out), 32'h002);
      nrm();
      check_eq("seq2_ir",   32'(bus.instr_out), 32'h003);
      check_eq("seq2_irpc", 32'(bus.ir_pc),     32'h002);
      nrm(); nrm(); nrm();
      check_eq("pre_br_irpc", 32'(bus.ir_pc), 32'h005);

      // Absolute branch. The slot after the branch is flushed, and the
      // target arrives valid one cycle later. A branch request against the
      // flushed slot is ignored.
      tick(1'b0, 1'b0, 1'b1, 1'b0, 10'h020, 1'b0);
      check_eq("abs_pc",    32'(bus.pc),          32'h020);
      check_eq("abs_valid", 32'(bus.instr_valid), 32'h0);
      tick(1'b0, 1'b0, 1'b1, 1'b0, 10'h100, 1'b0);
      check_eq("abs_tgt_irpc",  32'(bus.ir_pc),       32'h020);
      check_eq("abs_tgt_valid", 32'(bus.instr_valid), 32'h1);
      check_eq("abs_tgt_ir",    32'(bus.instr_out),   32'h021);

      // Relative branch whose target wraps past the top of the address space.
      tick(1'b0, 1'b0, 1'b1, 1'b0, 10'h3FE, 1'b0);
      nrm();
      check_eq("rel_src_irpc", 32'(bus.ir_pc), 32'h3FE);
      tick(1'b0, 1'b0, 1'b1, 1'b1, 10'h004, 1'b0);
      check_eq("rel_wrap_pc", 32'(bus.pc), 32'h002);
      nrm();

      // Sequential increment wrap, then a negative relative offset.
      tick(1'b0, 1'b0, 1'b1, 1'b0, 10'h3FF, 1'b0);
      nrm();
      check_eq("inc_wrap_pc", 32'(bus.pc), 32'h000);
      tick(1'b0, 1'b0, 1'b1, 1'b1, 10'h3FC, 1'b0);
      check_eq("rel_neg_pc", 32'(bus.pc), 32'h3FB);
      tick(1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 1'b0);  // stall on a flushed slot
      nrm(); nrm();

      // Three stall cycles hold pc and IR while the cycle count advances.
      s_pc = m_pc; s_ir = m_ir; s_cc = m_cc;
      repeat (3) tick(1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 1'b0);
      check_eq("stall_pc", 32'(bus.pc),          32'(s_pc));
      check_eq("stall_ir", 32'(bus.instr_out),   32'(s_ir));
      check_eq("stall_cc", 32'(bus.cycle_count), 32'(s_cc + 16'd3));

      // A branch outranks a stall, and start is ignored while running.
      tick(1'b0, 1'b1, 1'b1, 1'b0, 10'h040, 1'b0);
      tick(1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0);
      nrm();

      // Halt outranks a simultaneous branch.
      s_pc = m_pc;
      tick(1'b0, 1'b0, 1'b1, 1'b0, 10'h055, 1'b1);
      check_eq("halt_done",  32'(bus.done),        32'h1);
      check_eq("halt_pc",    32'(bus.pc),          32'(s_pc));
      check_eq("halt_valid", 32'(bus.instr_valid), 32'h0);
      s_cc = m_cc;
      tick(1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b1);
      tick(1'b0, 1'b1, 1'b1, 1'b0, 10'h011, 1'b0);
      check_eq("halted_cc_hold", 32'(bus.cycle_count), 32'(s_cc));

      // Restart from HALTED.
      tick(1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0);
      check_eq("restart_done", 32'(bus.done),        32'h0);
      check_eq("restart_pc",   32'(bus.pc),          32'(c_start));
      check_eq("restart_cc",   32'(bus.cycle_count), 32'h0);

      // The cycle count saturates.
      repeat (65540) nrm();
      check_eq("cc_saturate", 32'(bus.cycle_count), 32'hFFFF);
      tick(1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b1);
      check_eq("cc_sat_halt", 32'(bus.cycle_count), 32'hFFFF);
      tick(1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0);
      nrm(); nrm(); nrm();

      // Pulse reset mid-run, with a stall and a branch request pending. The
      // outputs must clear without a clock edge.
      bus.stall     = 1'b1;
      bus.branch_en = 1'b1;
      #1;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_reset_values("async_rst");
      @(posedge clk);
      #2;
      rst_n = 1'b1;

      // After reset the unit waits in IDLE until start.
      nrm(); nrm();
      tick(1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0);
      nrm();
      check_eq("post_rst_ir", 32'(bus.instr_out), 32'h001);
      nrm();

      check_eq("sb_drain", 32'(sb_q.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
